// File: rtl/j1_io_pkg.sv
// j1_io_pkg: shared definitions for the J1 UART I/O peripheral.
//   - register offsets decoded from mem_addr[1:0]
//   - STATUS register bit positions
//   - transmitter and receiver state encodings
package j1_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_READY  = 0;
    localparam int ST_RX_AVAIL  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/j1_sync_fifo.sv
// j1_sync_fifo: small synchronous FIFO with show-ahead head output.
// Ports:
//   clk, resetq      clock, asynchronous active-low reset (empties FIFO)
//   push, din        write request and data; ignored when full unless popping
//   pop              read request; ignored when empty
//   head             oldest entry (valid while !empty)
//   full, empty      occupancy flags
//   count            number of stored entries
module j1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetq,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot this push needs.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped UART for the J1 I/O bus.
// Ports:
//   clk, resetq   clock, asynchronous active-low reset
//   io_rd, io_wr  core I/O strobes; mem_addr selects, dout is write data
//   io_din        combinational read data (0 when not selected)
//   uart_rx       asynchronous serial input
//   uart_tx       registered serial output (idle high)
//   rx_irq        registered, high while the RX FIFO holds data
// Bus handshake: there is no ready/stall. A strobe (io_wr or io_rd) high at
// a clock edge with the block selected is the transaction; it is always
// accepted in that cycle. Read data is valid whenever the address is valid.
module j1_uart_io
    import j1_io_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'hF000,
    parameter logic [15:0] DIV_RST    = 16'd433,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] offset;
    logic       wr_data, wr_div, wr_ctrl, rd_pop;

    assign sel     = (mem_addr[15:2] == BASE[15:2]);
    assign offset  = mem_addr[1:0];
    assign wr_data = io_wr & sel & (offset == REG_DATA);
    assign wr_div  = io_wr & sel & (offset == REG_DIV);
    assign wr_ctrl = io_wr & sel & (offset == REG_CTRL);

    // ---------------- state ----------------
    logic [15:0] div;
    logic [7:0]  tx_hold;
    logic        tx_full;
    logic        overrun, frame_err;

    tx_state_t   tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        tx_load, tx_line_d;

    rx_state_t   rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_s1, rx_s2, rx_prev;
    logic        stop_ok, stop_bad, rx_push;

    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign rd_pop  = io_rd & sel & (offset == REG_DATA) & ~fifo_empty;
    assign rx_push = stop_ok & (~fifo_full | rd_pop);

    // ---------------- TX next state ----------------
    always_comb begin
        tx_state_d = tx_state;
        tx_load    = 1'b0;
        tx_shift_d = tx_shift;
        tx_bit_d   = tx_bit;
        tx_line_d  = 1'b1;
        unique case (tx_state)
            TX_IDLE: if (tx_full) begin
                tx_state_d = TX_START;
                tx_load    = 1'b1;
            end
            TX_START: if (tx_cnt == 16'd0) tx_state_d = TX_DATA;
            TX_DATA: if (tx_cnt == 16'd0) begin
                tx_shift_d = {1'b0, tx_shift[7:1]};
                tx_bit_d   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt == 16'd0) begin
                // A byte already waiting starts straight away so that
                // back-to-back frames have no idle gap between them.
                if (tx_full) begin
                    tx_state_d = TX_START;
                    tx_load    = 1'b1;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
        if (tx_load) tx_shift_d = tx_hold;
        if (tx_state == TX_START) tx_bit_d = 3'd0;
        // Each bit lasts div+1 clocks; reload at every bit boundary so a
        // divisor change takes effect from the next bit.
        tx_cnt_d = (tx_state == TX_IDLE || tx_cnt == 16'd0) ? div : tx_cnt - 16'd1;
        unique case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // ---------------- RX next state ----------------
    always_comb begin
        rx_state_d = rx_state;
        rx_shift_d = rx_shift;
        rx_bit_d   = rx_bit;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        unique case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) rx_state_d = RX_START;
            RX_START: if (rx_cnt == 16'd0) begin
                // Line back high at mid-start: treat as a glitch.
                rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
                rx_bit_d   = 3'd0;
            end
            RX_DATA: if (rx_cnt == 16'd0) begin
                rx_shift_d = {rx_s2, rx_shift[7:1]};
                rx_bit_d   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt == 16'd0) begin
                rx_state_d = RX_IDLE;
                stop_ok    = rx_s2;
                stop_bad   = ~rx_s2;
            end
        endcase
        // Idle preloads half a bit so the start bit is sampled mid-bit.
        if (rx_state == RX_IDLE)   rx_cnt_d = div >> 1;
        else if (rx_cnt == 16'd0)  rx_cnt_d = div;
        else                       rx_cnt_d = rx_cnt - 16'd1;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state  <= TX_IDLE;
            rx_state  <= RX_IDLE;
            tx_cnt    <= 16'd0;
            rx_cnt    <= 16'd0;
            tx_bit    <= 3'd0;
            rx_bit    <= 3'd0;
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            uart_tx   <= 1'b1;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            div       <= DIV_RST;
            tx_hold   <= 8'h00;
            tx_full   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            rx_state <= rx_state_d;
            tx_cnt   <= tx_cnt_d;
            rx_cnt   <= rx_cnt_d;
            tx_bit   <= tx_bit_d;
            rx_bit   <= rx_bit_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            uart_tx  <= tx_line_d;
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;

            if (wr_div) div <= dout;

            // Load and write are exclusive: load needs full, write needs empty.
            if (tx_load) tx_full <= 1'b0;
            if (wr_data && !tx_full) begin
                tx_hold <= dout[7:0];
                tx_full <= 1'b1;
            end

            // Clears come first so an error in the same cycle still sticks.
            if (wr_ctrl && dout[0]) overrun   <= 1'b0;
            if (wr_ctrl && dout[1]) frame_err <= 1'b0;
            if (stop_ok && fifo_full && !rd_pop) overrun <= 1'b1;
            if (stop_bad) frame_err <= 1'b1;

            // Tracks the FIFO's next occupancy so it changes with the count.
            rx_irq <= rx_push | (~fifo_empty & ~(rd_pop & (fifo_count == CW'(1))));
        end
    end

    // ---------------- RX FIFO ----------------
    j1_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .din    (rx_shift),
        .pop    (rd_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // ---------------- read mux ----------------
    always_comb begin
        io_din = 16'h0000;
        if (sel) begin
            unique case (offset)
                REG_DATA:   io_din = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
                REG_STATUS: begin
                    io_din[ST_TX_READY]  = ~tx_full;
                    io_din[ST_RX_AVAIL]  = ~fifo_empty;
                    io_din[ST_RX_FULL]   = fifo_full;
                    io_din[ST_OVERRUN]   = overrun;
                    io_din[ST_FRAME_ERR] = frame_err;
                end
                REG_DIV:    io_din = div;
                default:    io_din = 16'h0000;
            endcase
        end
    end

endmodule

// File: doc/j1_uart_io.md
# j1_uart_io

Memory-mapped UART peripheral on the J1 core's I/O bus, directly downstream of the core. It decodes `io_rd`, `io_wr` and `mem_addr`, and takes write data from `dout`. It returns read data on `io_din` combinationally, in the same cycle, so that the core latches it into `st0` at the next edge. It contains a double-buffered transmitter, an oversampling-free mid-bit receiver, and a 4-entry RX FIFO.

## Interface
Parameters:
- `BASE`, `16'hF000`: I/O base address; the block is selected when `mem_addr[15:2] == BASE[15:2]`.
- `DIV_RST`, `16'd433`: reset value of the divisor register. Bit period is DIV+1 clocks.
- `FIFO_DEPTH`, `4`: RX FIFO entries; must be a power of two.

Ports:
- `clk`, input, 1: clock.
- `resetq`, input, 1: reset, asynchronous, active-low.
- `io_rd`, input, 1: I/O read strobe from the core; qualifies read side effects.
- `io_wr`, input, 1: I/O write strobe from the core.
- `mem_addr`, input, 16: I/O address (core `st0`).
- `dout`, input, 16: write data (core `st1`).
- `io_din`, output, 16: read data, combinational; `16'h0000` when not selected.
- `uart_rx`, input, 1: asynchronous serial input.
- `uart_tx`, output, 1: serial output, registered.
- `rx_irq`, output, 1: registered; high while the RX FIFO is non-empty.

## Operation
- **Register offsets** (`mem_addr[1:0]`):
  - 0 DATA: a write loads `dout[7:0]` into the TX holding register. A read returns `{8'h00, rx_head}` and pops the RX FIFO.
  - 1 STATUS, read-only: bit0 `tx_ready` (holding register empty), bit1 `rx_avail`, bit2 `rx_full`, bit3 `overrun` (sticky), bit4 `frame_err` (sticky). Bits 15:5 read 0.
  - 2 DIVISOR: read/write, 16 bits.
  - 3 CONTROL: write-only; writing bit0=1 clears `overrun`, writing bit1=1 clears `frame_err`. Reads return 0.
- **Read data and side effects:** `io_din` depends only on `mem_addr` and state, not on `io_rd`. Side effects (the pop) occur only at a clock edge where `io_rd` is high and DATA is selected.
- **DATA write with holding register full:** the byte is dropped and no flag is set.
- **DATA read with FIFO empty:** returns `16'h0000` and does not pop.
- **TX FSM:**
  - IDLE → START when the holding register is full. The holding register transfers to the shifter on that edge and `tx_ready` rises.
  - START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each state lasts DIV+1 clocks. `uart_tx` is 1 in IDLE and STOP.
- **RX synchronisation:** `uart_rx` passes through a 2-flop synchronizer.
- **RX FSM:**
  - IDLE → START on a synchronized 1→0 transition.
  - In START, the line is sampled after `DIV>>1` clocks. If it is high the start is a glitch and the FSM returns to IDLE. Otherwise it moves to DATA.
  - DATA samples 8 bits at DIV+1 intervals.
  - STOP samples once. If the stop bit is 0: set `frame_err` and discard the byte. If it is 1: push the byte. If the FIFO is full, set `overrun` and drop the new byte.
  - STOP then returns to IDLE.
- **Push and pop in the same cycle:** both take effect and the count is unchanged. With the FIFO full, such a push is not an overrun.
- **DIVISOR write mid-frame:** the bit counters reload from DIVISOR at each bit boundary, so the new value applies from the next bit.
- **Reset:**
  - `uart_tx`=1, `rx_irq`=0.
  - FIFO empty, holding register empty (`tx_ready`=1).
  - Both FSMs in IDLE, flags 0, DIVISOR=`DIV_RST`.
  - Reset mid-frame aborts immediately and `uart_tx` returns to 1 asynchronously.

## Timing
- **TX latency:** a DATA write at edge N puts `uart_tx`=0 (start bit) from edge N+1 when the shifter is idle. A full frame lasts 10×(DIV+1) clocks.
- **Status visibility:** `tx_ready` reads 0 in cycle N+1, the cycle after the edge-N write, and 1 again from N+2 when the shifter was idle.
- **Read latency:** zero-cycle combinational path from `mem_addr` to `io_din`.
- **`rx_irq`:** rises the cycle after the push edge and falls the cycle after the pop that empties the FIFO.
- **Start sampling:** the start bit is sampled (DIV>>1)+2 clocks after the falling edge on `uart_rx`; the extra 2 clocks are synchronizer delay.

## Structure
- Package `j1_io_pkg` holds:
  - register offsets `REG_DATA`/`REG_STATUS`/`REG_DIV`/`REG_CTRL`;
  - STATUS bit indices;
  - TX/RX state enums (IDLE, START, DATA, STOP).
- Sub-module `j1_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/head) implements the RX FIFO. TX and RX FSMs stay inline.

## Test plan
- **Reset:** after reset, read STATUS → `16'h0001`; read DIVISOR → 433; `uart_tx`=1.
- **TX frame:** write DIVISOR=3, then write DATA=`16'h00A5` → `uart_tx` carries 0,1,0,1,0,0,1,0,1,1, each for 4 clocks, starting the edge after the write.
- **TX back-to-back:** with DIV=3, two DATA writes with `tx_ready` checked between them → the frames are contiguous and a third write while `tx_ready`=0 is dropped.
- **RX loopback:** drive byte `8'h3C` at DIV=7 → `rx_irq`=1. Read DATA → `16'h003C`; `rx_irq`=0 next cycle. A second read returns `16'h0000`.
- **RX overflow:** send 5 bytes 1..5 with no reads → `rx_full`=1 and `overrun`=1. Reads return 1,2,3,4; CONTROL write `16'h0001` clears `overrun`.
- **RX errors:**
  - A 1-clock low glitch on `uart_rx` pushes nothing.
  - A frame with stop bit 0 sets `frame_err`; FIFO unchanged.
  - Asserting `resetq`=0 mid-RX frame leaves the FIFO empty after release.
